// File: rtl/dac_playback_ctrl.sv
// DAC playback sequencer: pops an FWFT sample FIFO at a programmable rate and
// presents paired channel codes, in one-shot burst or continuous streaming mode.
module dac_playback_ctrl #(
    parameter int                 DATA_W    = 16,
    parameter logic [DATA_W-1:0]  IDLE_CODE = 16'h8000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [31:0]           sample_count,
    input  logic [15:0]           rate_div,
    input  logic [2*DATA_W-1:0]   fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_W-1:0]     dac_data_1,
    output logic [DATA_W-1:0]     dac_data_2,
    output logic                  dac_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun,
    output logic [31:0]           words_sent
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [15:0]       div_cnt_r;
    logic [15:0]       rate_div_r;
    logic [31:0]       remaining_r;
    logic              cont_r;
    logic              tick_s;
    logic              start_ok_s;
    logic              pop_s;
    logic [DATA_W-1:0] data_1_r;
    logic [DATA_W-1:0] data_2_r;
    logic              dac_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              underrun_r;
    logic [31:0]       words_sent_r;

    // Tick, start qualification, pop strobe and next-state decode.
    always_comb begin
        tick_s      = (div_cnt_r == 16'd0);
        start_ok_s  = start & ~stop & (continuous | (sample_count != 32'd0));
        pop_s       = (state_r == S_RUN) & tick_s & ~fifo_empty & ~stop;
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) state_nxt_s = S_PRIME;
                else            state_nxt_s = S_IDLE;
            end
            S_PRIME: begin
                if (stop)             state_nxt_s = S_IDLE;
                else if (!fifo_empty) state_nxt_s = S_RUN;
                else                  state_nxt_s = S_PRIME;
            end
            S_RUN: begin
                // Only a one-shot pop of the final word leaves RUN without stop.
                if (stop)                                          state_nxt_s = S_IDLE;
                else if (pop_s && !cont_r && remaining_r == 32'd1) state_nxt_s = S_HOLD;
                else                                               state_nxt_s = S_RUN;
            end
            S_HOLD: begin
                if (stop || tick_s) state_nxt_s = S_IDLE;
                else                state_nxt_s = S_HOLD;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Sequencer state, rate divider, sample outputs and status registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            div_cnt_r    <= 16'd0;
            rate_div_r   <= 16'd0;
            remaining_r  <= 32'd0;
            cont_r       <= 1'b0;
            data_1_r     <= IDLE_CODE;
            data_2_r     <= IDLE_CODE;
            dac_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            underrun_r   <= 1'b0;
            words_sent_r <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != S_IDLE);
            dac_valid_r <= pop_s;
            done_r      <= (state_r == S_HOLD) & ~stop & tick_s;
            case (state_r)
                S_IDLE: begin
                    if (start_ok_s) begin
                        cont_r       <= continuous;
                        remaining_r  <= sample_count;
                        rate_div_r   <= rate_div;
                        underrun_r   <= 1'b0;
                        words_sent_r <= 32'd0;
                    end
                end
                S_PRIME: begin
                    div_cnt_r <= 16'd0;
                end
                S_RUN: begin
                    if (!stop) begin
                        div_cnt_r <= tick_s ? rate_div_r : (div_cnt_r - 16'd1);
                        if (pop_s) begin
                            data_1_r <= fifo_dout[2*DATA_W-1:DATA_W];
                            data_2_r <= fifo_dout[DATA_W-1:0];
                            if (words_sent_r != 32'hFFFF_FFFF) begin
                                words_sent_r <= words_sent_r + 32'd1;
                            end
                            if (!cont_r) begin
                                remaining_r <= remaining_r - 32'd1;
                            end
                        end else if (tick_s) begin
                            underrun_r <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stop) begin
                        div_cnt_r <= tick_s ? rate_div_r : (div_cnt_r - 16'd1);
                    end
                end
                default: begin
                    div_cnt_r <= 16'd0;
                end
            endcase
            // Any return to IDLE parks both channels at midscale.
            if (state_nxt_s == S_IDLE) begin
                data_1_r <= IDLE_CODE;
                data_2_r <= IDLE_CODE;
            end
        end
    end

    assign fifo_rd_en = pop_s;
    assign dac_data_1 = data_1_r;
    assign dac_data_2 = data_2_r;
    assign dac_valid  = dac_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign underrun   = underrun_r;
    assign words_sent = words_sent_r;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed testbench for dac_playback_ctrl with a small FWFT FIFO model.
module tb_dac_playback_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [31:0] sample_count;
    logic [15:0] rate_div;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] dac_data_1;
    logic [15:0] dac_data_2;
    logic        dac_valid;
    logic        busy;
    logic        done;
    logic        underrun;
    logic [31:0] words_sent;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:31];
    logic [4:0]  rd_ptr;
    logic [4:0]  wr_ptr;

    dac_playback_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .sample_count (sample_count),
        .rate_div     (rate_div),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .dac_data_1   (dac_data_1),
        .dac_data_2   (dac_data_2),
        .dac_valid    (dac_valid),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .words_sent   (words_sent)
    );

    always #5 clk = ~clk;

    assign fifo_dout  = mem[rd_ptr];
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 5'd1;
    end

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    // Drives one start pulse; returns at the falling edge of the PRIME cycle.
    task automatic do_start(input logic cont, input logic [31:0] cnt, input logic [15:0] rd);
        continuous   = cont;
        sample_count = cnt;
        rate_div     = rd;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        continuous = 1'b1;
        push(32'h1234_5678);
        repeat (3) @(negedge clk);
        checks++; if (dac_data_1 !== 16'h8000) begin errors++; $display("FAIL reset_data1 got %h expected 8000", dac_data_1); end
        checks++; if (dac_data_2 !== 16'h8000) begin errors++; $display("FAIL reset_data2 got %h expected 8000", dac_data_2); end
        checks++; if ({dac_valid, busy, done, underrun} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b expected 0000", {dac_valid, busy, done, underrun}); end
        checks++; if (words_sent !== 32'd0) begin errors++; $display("FAIL reset_words got %0d expected 0", words_sent); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b expected 0", fifo_rd_en); end
        start   = 1'b0;
        reset_n = 1'b1;
        flush();
        @(negedge clk);
    endtask

    task automatic test_oneshot();
        int nv = 0, last_v = 0, done_c = 0;
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) push(32'h0001_8001 + 32'(i) * 32'h0001_0001);
        do_start(1'b0, 32'd4, 16'd2);
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            if (dac_valid) begin
                exp = 32'h0001_8001 + 32'(nv) * 32'h0001_0001;
                checks++; if ({dac_data_1, dac_data_2} !== exp) begin errors++; $display("FAIL oneshot_data got %h expected %h", {dac_data_1, dac_data_2}, exp); end
                checks++; if (c != 3 + 3 * nv) begin errors++; $display("FAIL oneshot_valid_cycle got %0d expected %0d", c, 3 + 3 * nv); end
                nv++;
                last_v = c;
            end
            if (c == 10) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL oneshot_busy got %b expected 1", busy); end
            end
            if (done) begin
                done_c = c;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy_at_done got %b expected 0", busy); end
                checks++; if ({dac_data_1, dac_data_2} !== 32'h8000_8000) begin errors++; $display("FAIL oneshot_idle_code got %h expected 80008000", {dac_data_1, dac_data_2}); end
            end
            @(negedge clk);
        end
        checks++; if (nv != 4) begin errors++; $display("FAIL oneshot_valid_count got %0d expected 4", nv); end
        checks++; if (done_c != last_v + 3) begin errors++; $display("FAIL oneshot_done_cycle got %0d expected %0d", done_c, last_v + 3); end
        checks++; if (words_sent !== 32'd4) begin errors++; $display("FAIL oneshot_words got %0d expected 4", words_sent); end
    endtask

    task automatic test_back_to_back();
        int nv = 0, first_v = 0, last_v = 0, nrd = 0, first_rd = 0, last_rd = 0, done_c = 0;
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) push(32'hA000_0100 + 32'(i) * 32'h0001_0001);
        do_start(1'b0, 32'd8, 16'd0);
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            if (fifo_rd_en) begin
                nrd++;
                if (first_rd == 0) first_rd = c;
                last_rd = c;
            end
            if (dac_valid) begin
                exp = 32'hA000_0100 + 32'(nv) * 32'h0001_0001;
                checks++; if ({dac_data_1, dac_data_2} !== exp) begin errors++; $display("FAIL b2b_data got %h expected %h", {dac_data_1, dac_data_2}, exp); end
                nv++;
                if (first_v == 0) first_v = c;
                last_v = c;
            end
            if (done) done_c = c;
            @(negedge clk);
        end
        checks++; if (nrd != 8 || last_rd - first_rd != 7) begin errors++; $display("FAIL b2b_rd_en got %0d pops over cycles %0d..%0d expected 8 consecutive", nrd, first_rd, last_rd); end
        checks++; if (first_rd != 2) begin errors++; $display("FAIL b2b_first_pop got cycle %0d expected 2", first_rd); end
        checks++; if (nv != 8 || last_v - first_v != 7) begin errors++; $display("FAIL b2b_valid got %0d valids over cycles %0d..%0d expected 8 consecutive", nv, first_v, last_v); end
        checks++; if (done_c != last_v + 1) begin errors++; $display("FAIL b2b_done_cycle got %0d expected %0d", done_c, last_v + 1); end
    endtask

    task automatic test_underrun();
        push(32'h1111_2222);
        push(32'h3333_4444);
        do_start(1'b1, 32'd0, 16'd1);
        for (int c = 1; c <= 12; c++) begin
            if (c >= 6 && c <= 9) begin
                checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL underrun_no_pop cycle %0d got %b expected 0", c, fifo_rd_en); end
            end
            if (c == 7) begin
                checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got %b expected 1", underrun); end
            end
            if (c == 9) begin
                checks++; if ({dac_data_1, dac_data_2, dac_valid} !== {32'h3333_4444, 1'b0}) begin errors++; $display("FAIL underrun_hold got %h/%b expected 33334444/0", {dac_data_1, dac_data_2}, dac_valid); end
                push(32'h5555_6666);
                push(32'h7777_8888);
            end
            if (c == 11) begin
                checks++; if ({dac_valid, dac_data_1, dac_data_2, underrun} !== {1'b1, 32'h5555_6666, 1'b1}) begin errors++; $display("FAIL underrun_resume got %b/%h/%b expected 1/55556666/1", dac_valid, {dac_data_1, dac_data_2}, underrun); end
                stop = 1'b1;
            end
            if (c == 12) begin
                checks++; if ({busy, underrun, words_sent} !== {1'b0, 1'b1, 32'd3}) begin errors++; $display("FAIL underrun_after_stop got busy %b underrun %b words %0d expected 0 1 3", busy, underrun, words_sent); end
            end
            @(negedge clk);
            stop = 1'b0;
        end
        flush();
    endtask

    task automatic test_stop();
        int seen_done = 0;
        for (int i = 0; i < 4; i++) push(32'hC000_0000 + 32'(i));
        do_start(1'b0, 32'd4, 16'd1);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL restart_clears_underrun got %b expected 0", underrun); end
        repeat (3) @(negedge clk);
        stop = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stop_no_pop got %b expected 0", fifo_rd_en); end
        @(negedge clk);
        stop = 1'b0;
        checks++; if ({busy, dac_valid, dac_data_1, dac_data_2} !== {2'b00, 32'h8000_8000}) begin errors++; $display("FAIL stop_idle got busy %b valid %b data %h expected 0 0 80008000", busy, dac_valid, {dac_data_1, dac_data_2}); end
        checks++; if (words_sent !== 32'd1) begin errors++; $display("FAIL stop_words got %0d expected 1", words_sent); end
        for (int c = 0; c < 6; c++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        checks++; if (seen_done != 0 || (wr_ptr - rd_ptr) != 5'd3) begin errors++; $display("FAIL stop_no_done got %0d done pulses and %0d words left expected 0 and 3", seen_done, wr_ptr - rd_ptr); end
    endtask

    task automatic test_illegal_starts();
        int seen_done = 0, done_c = 0;
        do_start(1'b0, 32'd0, 16'd0);
        for (int c = 0; c < 4; c++) begin
            if (busy || done) seen_done++;
            @(negedge clk);
        end
        checks++; if (seen_done != 0 || words_sent !== 32'd1) begin errors++; $display("FAIL zero_count_start got %0d busy/done cycles words %0d expected 0 and 1", seen_done, words_sent); end
        stop = 1'b1;
        do_start(1'b1, 32'd5, 16'd0);
        stop = 1'b0;
        @(negedge clk);
        checks++; if ({busy, fifo_rd_en} !== 2'b00) begin errors++; $display("FAIL start_with_stop got busy %b rd_en %b expected 0 0", busy, fifo_rd_en); end
        flush();
        for (int i = 0; i < 3; i++) push(32'hD000_0000 + 32'(i));
        do_start(1'b0, 32'd3, 16'd0);
        for (int c = 1; c <= 20 && done_c == 0; c++) begin
            if (c == 2) begin
                continuous   = 1'b1;
                sample_count = 32'd10;
                start        = 1'b1;
            end
            if (c == 4) begin
                checks++; if (words_sent !== 32'd2) begin errors++; $display("FAIL busy_start_words got %0d expected 2", words_sent); end
            end
            if (done) done_c = c;
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (done_c != 6 || words_sent !== 32'd3) begin errors++; $display("FAIL busy_start_ignored got done cycle %0d words %0d expected 6 and 3", done_c, words_sent); end
    endtask

    initial begin
        clk = 1'b0;
        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        continuous = 1'b0;
        sample_count = 32'd0;
        rate_div = 16'd0;
        rd_ptr = 5'd0;
        wr_ptr = 5'd0;
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_back_to_back();
        test_underrun();
        test_stop();
        test_illegal_starts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_playback_ctrl.md
# dac_playback_ctrl

Playback sequencer for the DAC direction of the SYZYGY data path. Host sample words arrive through a pipe-in endpoint into a first-word-fall-through FIFO. This block pops the FIFO at a programmable sample rate and presents paired 16-bit channel codes to the DAC serializer. It runs in the DAC clock domain. It supports one-shot bursts of a fixed word count or continuous streaming, and it reports FIFO underruns.

## Interface
Parameters:
- DATA_W, 16, sample width per channel; FIFO word is 2*DATA_W.
- IDLE_CODE, 16'h8000, midscale code driven on both channels while idle.

Ports:
- clk  in  1  DAC sample-domain clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins playback if idle.
- stop  in  1  one-cycle pulse; aborts playback.
- continuous  in  1  mode select, sampled on accepted start: 1 = stream until stop, 0 = one-shot.
- sample_count  in  32  one-shot word count, sampled on accepted start.
- rate_div  in  16  update period = rate_div+1 clk cycles, sampled on accepted start.
- fifo_dout  in  2*DATA_W  FWFT head word: [31:16] = channel 1, [15:0] = channel 2.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe; combinational.
- dac_data_1  out  DATA_W  channel 1 code; registered.
- dac_data_2  out  DATA_W  channel 2 code; registered.
- dac_valid  out  1  one-cycle pulse when a new sample pair is presented.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on one-shot completion.
- underrun  out  1  sticky; a sample tick occurred with the FIFO empty.
- words_sent  out  32  words popped since the last accepted start; saturates at 32'hFFFF_FFFF.

## Operation
- States: IDLE, PRIME, RUN, HOLD.
- IDLE:
  - start with stop low is accepted. It latches mode, sample_count (into remaining) and rate_div, clears underrun and words_sent, and goes to PRIME.
  - start is ignored if it arrives while busy, together with stop, or with continuous=0 and sample_count=0.
- PRIME: waits for fifo_empty=0, then goes to RUN with div_cnt=0.
- RUN:
  - tick = (div_cnt==0). On a tick div_cnt reloads to rate_div; otherwise it decrements.
  - tick with fifo_empty=0: fifo_rd_en=1. The head word is registered onto dac_data_1/2, dac_valid pulses, words_sent increments, and remaining decrements in one-shot mode.
  - tick with fifo_empty=1: underrun set. Outputs hold their previous values, dac_valid=0, nothing is popped, remaining is unchanged, and the state stays RUN.
  - One-shot pop that brings remaining to 0 → HOLD. Continuous mode never enters HOLD.
- HOLD:
  - div_cnt keeps counting with no pops.
  - When div_cnt==0 → IDLE with a done pulse. The last sample is therefore held for exactly rate_div+1 cycles.
- stop in PRIME, RUN or HOLD → IDLE at the next edge.
  - It has priority over a same-cycle tick, so fifo_rd_en=0 in that cycle.
  - No done pulse.
  - underrun and words_sent are retained.
- Entering IDLE by any path: dac_data_1/2 = IDLE_CODE.
- fifo_rd_en = (state==RUN) & tick & ~fifo_empty & ~stop. It is never asserted in any other state.

## Timing
- Reset values: state IDLE, dac_data_1/2 = IDLE_CODE, dac_valid 0, busy 0, done 0, underrun 0, words_sent 0, fifo_rd_en 0.
- Start latency with a non-empty FIFO:
  - start sampled at edge 0; PRIME during cycle 1; RUN from edge 2.
  - First fifo_rd_en in cycle 2; dac_valid and the first data visible in cycle 3.
- Pop-to-output latency: 1 cycle.
- Sustained rate: one pop every rate_div+1 cycles; rate_div=0 pops every cycle.
- Final one-shot pop in cycle t:
  - Sample visible from t+1.
  - done=1 and IDLE_CODE in cycle t+1+rate_div+1.
  - busy falls in the same cycle as done.
- done, dac_valid and underrun are registered outputs.
- words_sent and underrun are stable while idle.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with start=1 → all outputs at reset values, fifo_rd_en=0, IDLE_CODE on both channels.
- One-shot:
  - Stimulus: FIFO preloaded with 4 words 0x0001_8001 … 0x0004_8004; continuous=0, sample_count=4, rate_div=2; start.
  - Required: dac_valid pulses every 3 cycles with ch1 = 1..4 and ch2 = 0x8001..0x8004; words_sent=4; done 3 cycles after the last dac_valid; then IDLE_CODE and busy=0.
- Back-to-back: rate_div=0, 8 words preloaded, one-shot count 8 → fifo_rd_en high for 8 consecutive cycles, 8 consecutive dac_valid, then done one cycle after the last valid.
- Underrun:
  - Stimulus: continuous=1, rate_div=1, FIFO holding 2 words, refilled only after 6 cycles.
  - Required: underrun=1 and outputs hold the 2nd sample while no pops occur; streaming resumes on refill with underrun still 1; the next accepted start clears underrun.
- Stop mid-run:
  - Stimulus: stop asserted in a tick cycle with the FIFO non-empty.
  - Required: no pop in that cycle, IDLE at the next edge, IDLE_CODE on both channels, no done, words_sent retained.
- Illegal starts:
  - start while busy → no effect on remaining or words_sent.
  - start with sample_count=0 in one-shot mode → stays IDLE, busy=0, no done.
  - start and stop in the same cycle → stays IDLE.
